// File: rtl/vx_dma_engine.sv
// vx_dma_engine: DMA responder copying words between global and local memory, one read in flight.
// Define DMA_ENGINE_PERF_EN to build the busy-cycle and words-copied counters.
module vx_dma_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 16,
  parameter int TAG_WIDTH  = 4,
  parameter int WORD_BYTES = 4,
  parameter int REQ_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_src_addr,
  input  logic [ADDR_WIDTH-1:0]   req_dst_addr,
  input  logic [SIZE_WIDTH-1:0]   req_size,
  input  logic                    req_to_lmem,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [TAG_WIDTH-1:0]    rsp_tag,
  output logic                    gmem_req_valid,
  input  logic                    gmem_req_ready,
  output logic                    gmem_req_rw,
  output logic [ADDR_WIDTH-1:0]   gmem_req_addr,
  output logic [8*WORD_BYTES-1:0] gmem_req_data,
  input  logic                    gmem_rsp_valid,
  output logic                    gmem_rsp_ready,
  input  logic [8*WORD_BYTES-1:0] gmem_rsp_data,
  output logic                    lmem_req_valid,
  input  logic                    lmem_req_ready,
  output logic                    lmem_req_rw,
  output logic [ADDR_WIDTH-1:0]   lmem_req_addr,
  output logic [8*WORD_BYTES-1:0] lmem_req_data,
  input  logic                    lmem_rsp_valid,
  output logic                    lmem_rsp_ready,
  input  logic [8*WORD_BYTES-1:0] lmem_rsp_data,
  output logic [31:0]             perf_busy_cycles,
  output logic [31:0]             perf_words
);
  localparam int DW     = 8 * WORD_BYTES;
  localparam int WB_LOG = $clog2(WORD_BYTES);
  localparam int PTR_W  = $clog2(REQ_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(WORD_BYTES);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [SIZE_WIDTH-1:0] size;
    logic                  to_lmem;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_WR, S_DONE} state_t;

  req_t                fifo_mem [REQ_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q;
  logic                ready_en_q;
  logic                push, pop;
  req_t                head;
  logic [SIZE_WIDTH:0] size_rnd;
  logic [SIZE_WIDTH-1:0] head_nwords;
  logic                head_src_p;

  assign req_ready   = ready_en_q && (count_q != (PTR_W+1)'(REQ_DEPTH));
  assign push        = req_valid && req_ready;
  assign head        = fifo_mem[rd_ptr_q];
  assign size_rnd    = {1'b0, head.size} + (SIZE_WIDTH+1)'(WORD_BYTES - 1);
  assign head_nwords = SIZE_WIDTH'(size_rnd >> WB_LOG);
  assign head_src_p  = ~head.to_lmem;

  // NOTE: payload storage has no reset; the pointers and count alone decide validity, so reset still flushes it.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{req_src_addr, req_dst_addr, req_size, req_to_lmem, req_tag};
  end

  // NOTE: every sequential assignment is non-blocking so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // Memory ports as two-entry arrays: index 0 is gmem, index 1 is lmem.
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [SIZE_WIDTH-1:0] cnt_q;
  logic                  dir_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  rsp_valid_q;
  logic [TAG_WIDTH-1:0]  rsp_tag_q;
  logic [1:0]            mreq_valid_q, mreq_rw_q, mrsp_ready_q;
  logic [ADDR_WIDTH-1:0] mreq_addr_q [2];
  logic [DW-1:0]         mreq_data_q [2];
  logic [1:0]            mreq_ready, mrsp_valid;
  logic [DW-1:0]         mrsp_data [2];
  logic                  src_p, dst_p;

  assign pop          = (state_q == S_IDLE) && (count_q != '0);
  assign src_p        = ~dir_q;
  assign dst_p        = dir_q;
  assign mreq_ready   = {lmem_req_ready, gmem_req_ready};
  assign mrsp_valid   = {lmem_rsp_valid, gmem_rsp_valid};
  assign mrsp_data[0] = gmem_rsp_data;
  assign mrsp_data[1] = lmem_rsp_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_tag_q    <= '0;
      mreq_valid_q <= '0;
      mreq_rw_q    <= '0;
      mrsp_ready_q <= '0;
      for (int p = 0; p < 2; p++) begin
        mreq_addr_q[p] <= '0;
        mreq_data_q[p] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: if (pop) begin
          src_q <= head.src & ALIGN_MASK;
          dst_q <= head.dst & ALIGN_MASK;
          cnt_q <= head_nwords;
          dir_q <= head.to_lmem;
          tag_q <= head.tag;
          if (head_nwords == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_tag_q   <= head.tag;
            state_q     <= S_DONE;
          end else begin
            mreq_valid_q[head_src_p] <= 1'b1;
            mreq_rw_q[head_src_p]    <= 1'b0;
            mreq_addr_q[head_src_p]  <= head.src & ALIGN_MASK;
            state_q                  <= S_RD;
          end
        end
        S_RD: if (mreq_ready[src_p]) begin
          mreq_valid_q[src_p] <= 1'b0;
          mrsp_ready_q[src_p] <= 1'b1;
          state_q             <= S_RWAIT;
        end
        S_RWAIT: if (mrsp_valid[src_p]) begin
          mrsp_ready_q[src_p] <= 1'b0;
          mreq_valid_q[dst_p] <= 1'b1;
          mreq_rw_q[dst_p]    <= 1'b1;
          mreq_addr_q[dst_p]  <= dst_q;
          mreq_data_q[dst_p]  <= mrsp_data[src_p];
          state_q             <= S_WR;
        end
        S_WR: if (mreq_ready[dst_p]) begin
          mreq_valid_q[dst_p] <= 1'b0;
          mreq_rw_q[dst_p]    <= 1'b0;
          src_q               <= src_q + STEP;
          dst_q               <= dst_q + STEP;
          cnt_q               <= cnt_q - SIZE_WIDTH'(1);
          if (cnt_q == SIZE_WIDTH'(1)) begin
            rsp_valid_q <= 1'b1;
            rsp_tag_q   <= tag_q;
            state_q     <= S_DONE;
          end else begin
            mreq_valid_q[src_p] <= 1'b1;
            mreq_addr_q[src_p]  <= src_q + STEP;
            state_q             <= S_RD;
          end
        end
        S_DONE: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_tag        = rsp_tag_q;
  assign gmem_req_valid = mreq_valid_q[0];
  assign gmem_req_rw    = mreq_rw_q[0];
  assign gmem_req_addr  = mreq_addr_q[0];
  assign gmem_req_data  = mreq_data_q[0];
  assign gmem_rsp_ready = mrsp_ready_q[0];
  assign lmem_req_valid = mreq_valid_q[1];
  assign lmem_req_rw    = mreq_rw_q[1];
  assign lmem_req_addr  = mreq_addr_q[1];
  assign lmem_req_data  = mreq_data_q[1];
  assign lmem_rsp_ready = mrsp_ready_q[1];

`ifdef DMA_ENGINE_PERF_EN
  logic [31:0] busy_q, words_q;
  logic        wr_fire;

  assign wr_fire = (state_q == S_WR) && mreq_ready[dst_p];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= '0;
      words_q <= '0;
    end else begin
      if (state_q != S_IDLE) busy_q <= busy_q + 32'd1;
      if (wr_fire)           words_q <= words_q + 32'd1;
    end
  end

  assign perf_busy_cycles = busy_q;
  assign perf_words       = words_q;
`else
  assign perf_busy_cycles = '0;
  assign perf_words       = '0;
`endif

endmodule

// File: tb/tb_vx_dma_engine.sv
// Directed self-checking bench for vx_dma_engine with gmem/lmem models that can inject random stalls.
module tb_vx_dma_engine;
  localparam int AW = 32;
  localparam int SW = 16;
  localparam int TW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_to_lmem;
  logic [AW-1:0] req_src_addr, req_dst_addr;
  logic [SW-1:0] req_size;
  logic [TW-1:0] req_tag;
  logic          rsp_valid, rsp_ready;
  logic [TW-1:0] rsp_tag;
  logic [31:0]   perf_busy_cycles, perf_words;

  // Index 0 is gmem, index 1 is lmem.
  logic          m_req_valid [2];
  logic          m_req_ready [2];
  logic          m_req_rw    [2];
  logic [AW-1:0] m_req_addr  [2];
  logic [DW-1:0] m_req_data  [2];
  logic          m_rsp_valid [2];
  logic          m_rsp_ready [2];
  logic [DW-1:0] m_rsp_data  [2];

  vx_dma_engine dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr),
    .req_size(req_size), .req_to_lmem(req_to_lmem), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .gmem_req_valid(m_req_valid[0]), .gmem_req_ready(m_req_ready[0]),
    .gmem_req_rw(m_req_rw[0]), .gmem_req_addr(m_req_addr[0]), .gmem_req_data(m_req_data[0]),
    .gmem_rsp_valid(m_rsp_valid[0]), .gmem_rsp_ready(m_rsp_ready[0]), .gmem_rsp_data(m_rsp_data[0]),
    .lmem_req_valid(m_req_valid[1]), .lmem_req_ready(m_req_ready[1]),
    .lmem_req_rw(m_req_rw[1]), .lmem_req_addr(m_req_addr[1]), .lmem_req_data(m_req_data[1]),
    .lmem_rsp_valid(m_rsp_valid[1]), .lmem_rsp_ready(m_rsp_ready[1]), .lmem_rsp_data(m_rsp_data[1]),
    .perf_busy_cycles(perf_busy_cycles), .perf_words(perf_words)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int p, input int i);
    return (p == 0 ? 32'h6000_0000 : 32'h9000_0000) + 32'(i) * 32'h0001_0003;
  endfunction

  // Memory models and transaction logs
  logic [31:0] mem [2][16384];
  logic [31:0] rd_log [2][$];
  logic [31:0] wa_log [2][$];
  logic [31:0] wd_log [2][$];
  bit          stall_en = 1'b0;
  logic        have_rd [2], rsp_fire [2], pend [2];
  logic [13:0] rd_idx [2];
  logic [AW-1:0] hold_addr [2];
  logic        hold_rw [2];
  logic [DW-1:0] hold_data [2];

  task automatic clear_logs();
    for (int p = 0; p < 2; p++) begin
      rd_log[p].delete();
      wa_log[p].delete();
      wd_log[p].delete();
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16384; i++) mem[p][i] = pat(p, i);
      m_req_ready[p] = 1'b0; m_rsp_valid[p] = 1'b0; m_rsp_data[p] = '0;
      have_rd[p] = 1'b0; rsp_fire[p] = 1'b0; pend[p] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!reset_n) begin
          m_req_ready[p] = 1'b0; m_rsp_valid[p] = 1'b0;
          have_rd[p] = 1'b0; rsp_fire[p] = 1'b0; pend[p] = 1'b0;
        end else begin
          if (rsp_fire[p]) begin
            m_rsp_valid[p] = 1'b0; rsp_fire[p] = 1'b0; have_rd[p] = 1'b0;
          end
          if (have_rd[p] && !m_rsp_valid[p] && (!stall_en || $urandom_range(0, 1) == 0)) begin
            m_rsp_valid[p] = 1'b1;
            m_rsp_data[p]  = mem[p][rd_idx[p]];
          end
          if (m_rsp_valid[p] && m_rsp_ready[p]) rsp_fire[p] = 1'b1;
          if (pend[p]) begin
            check("stall_valid_held", m_req_valid[p], 1'b1);
            check("stall_addr_held", m_req_addr[p], hold_addr[p]);
            check("stall_rw_held", m_req_rw[p], hold_rw[p]);
            if (hold_rw[p]) check("stall_data_held", m_req_data[p], hold_data[p]);
          end
          m_req_ready[p] = !stall_en || ($urandom_range(0, 2) != 0);
          pend[p] = 1'b0;
          if (m_req_valid[p]) begin
            if (m_req_ready[p]) begin
              if (m_req_rw[p]) begin
                mem[p][m_req_addr[p][15:2]] = m_req_data[p];
                wa_log[p].push_back(m_req_addr[p]);
                wd_log[p].push_back(m_req_data[p]);
              end else begin
                have_rd[p] = 1'b1;
                rd_idx[p]  = m_req_addr[p][15:2];
                rd_log[p].push_back(m_req_addr[p]);
              end
            end else begin
              pend[p] = 1'b1;
              hold_addr[p] = m_req_addr[p];
              hold_rw[p]   = m_req_rw[p];
              hold_data[p] = m_req_data[p];
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] size,
                      input logic to_l, input logic [3:0] tag);
    int n;
    n = 0;
    req_valid = 1'b1; req_src_addr = src; req_dst_addr = dst;
    req_size = size; req_to_lmem = to_l; req_tag = tag;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_accepted", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic [3:0] exp_tag, input int max_cyc, output int lat);
    lat = 0;
    while (!rsp_valid && lat < max_cyc) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_valid_seen", rsp_valid, 1'b1);
    check("rsp_tag", rsp_tag, exp_tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_dropped", rsp_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, got, seen_rsp, seen_req;
    logic clear;
    req_valid = 1'b0; rsp_ready = 1'b0; req_src_addr = '0; req_dst_addr = '0;
    req_size = '0; req_to_lmem = 1'b0; req_tag = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_tag", rsp_tag, 4'h0);
    for (int p = 0; p < 2; p++) begin
      check("rst_mreq_valid", m_req_valid[p], 1'b0);
      check("rst_mreq_rw", m_req_rw[p], 1'b0);
      check("rst_mreq_addr", m_req_addr[p], 32'h0);
      check("rst_mreq_data", m_req_data[p], 32'h0);
      check("rst_mrsp_ready", m_rsp_ready[p], 1'b0);
    end
    check("rst_perf_busy", perf_busy_cycles, 32'h0);
    check("rst_perf_words", perf_words, 32'h0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1'b1);

    // 64-byte gmem -> lmem copy, zero-wait memories
    clear_logs();
    send(32'h1000, 32'h200, 16'd64, 1'b1, 4'd3);
    check("t1_no_read_yet", m_req_valid[0], 1'b0);
    @(negedge clk);
    check("t1_first_read_valid", m_req_valid[0], 1'b1);
    check("t1_first_read_addr", m_req_addr[0], 32'h1000);
    check("t1_first_read_rw", m_req_rw[0], 1'b0);
    wait_rsp(4'd3, 200, lat);
    check("t1_latency", lat, 48);
    check("t1_nreads", rd_log[0].size(), 16);
    check("t1_nwrites", wa_log[1].size(), 16);
    check("t1_no_lmem_reads", rd_log[1].size(), 0);
    check("t1_no_gmem_writes", wa_log[0].size(), 0);
    for (int k = 0; k < 16; k++) begin
      check("t1_rd_addr", rd_log[0][k], 32'h1000 + 32'(4 * k));
      check("t1_wr_addr", wa_log[1][k], 32'h200 + 32'(4 * k));
      check("t1_wr_data", wd_log[1][k], pat(0, 32'h400 + k));
    end
    check("t1_gmem_rsp_ready_idle", m_rsp_ready[0], 1'b0);
    check("t1_lmem_rsp_ready_idle", m_rsp_ready[1], 1'b0);
`ifdef DMA_ENGINE_PERF_EN
    check("t1_perf_words", perf_words, 32'd16);
`else
    check("t1_perf_words_tied", perf_words, 32'd0);
    check("t1_perf_busy_tied", perf_busy_cycles, 32'd0);
`endif

    // Zero-size request
    clear_logs();
    send(32'h1000, 32'h200, 16'd0, 1'b1, 4'd5);
    wait_rsp(4'd5, 20, lat);
    check("t2_latency", lat, 1);
    check("t2_no_traffic", rd_log[0].size() + rd_log[1].size() + wa_log[0].size() + wa_log[1].size(), 0);

    // 6 bytes lmem -> gmem, unaligned addresses
    clear_logs();
    send(32'h802, 32'h3001, 16'd6, 1'b0, 4'd6);
    wait_rsp(4'd6, 100, lat);
    check("t3_lmem_reads", rd_log[1].size(), 2);
    check("t3_gmem_writes", wa_log[0].size(), 2);
    check("t3_rd_addr0", rd_log[1][0], 32'h800);
    check("t3_rd_addr1", rd_log[1][1], 32'h804);
    check("t3_wr_addr0", wa_log[0][0], 32'h3000);
    check("t3_wr_addr1", wa_log[0][1], 32'h3004);
    check("t3_wr_data0", wd_log[0][0], pat(1, 32'h200));
    check("t3_wr_data1", wd_log[0][1], pat(1, 32'h201));

    // Back-to-back requests with completions held off
    for (int t = 0; t < 5; t++) send(32'h0, 32'h0, 16'd0, 1'b1, 4'(t));
    check("t4_full_ready_low", req_ready, 1'b0);
    req_valid = 1'b1; req_tag = 4'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_stays_full", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    got = 0;
    clear = 1'b0;
    for (int c = 0; c < 100 && got < 6; c++) begin
      if (clear) begin req_valid = 1'b0; clear = 1'b0; end
      if (req_valid && req_ready) clear = 1'b1;
      if (rsp_valid) begin
        check("t4_order_tag", rsp_tag, 4'(got));
        got++;
      end
      @(negedge clk);
    end
    check("t4_all_completions", got, 6);
    rsp_ready = 1'b0;
    req_valid = 1'b0;

    // Random stalls on both ports, then copy the data back
    clear_logs();
    stall_en = 1'b1;
    send(32'h2000, 32'h400, 16'd40, 1'b1, 4'd9);
    wait_rsp(4'd9, 2000, lat);
    check("t5a_nwrites", wa_log[1].size(), 10);
    for (int k = 0; k < 10; k++) check("t5a_lmem_data", mem[1][32'h100 + k], pat(0, 32'h800 + k));
    send(32'h400, 32'h5000, 16'd40, 1'b0, 4'd10);
    wait_rsp(4'd10, 2000, lat);
    check("t5b_nreads", rd_log[1].size(), 10);
    for (int k = 0; k < 10; k++) check("t5b_gmem_data", mem[0][32'h1400 + k], pat(0, 32'h800 + k));
    stall_en = 1'b0;

    // Reset during the third word of a 16-word copy, with a queued request behind it
    clear_logs();
    send(32'h1200, 32'h600, 16'd64, 1'b1, 4'd7);
    send(32'h0, 32'h0, 16'd0, 1'b1, 4'd8);
    repeat (6) @(negedge clk);
    check("t6_writes_before_reset", wa_log[1].size(), 2);
    #2 reset_n = 1'b0;
    #1;
    check("t6_gmem_valid_cleared", m_req_valid[0], 1'b0);
    check("t6_lmem_valid_cleared", m_req_valid[1], 1'b0);
    check("t6_rsp_valid_cleared", rsp_valid, 1'b0);
    check("t6_req_ready_low", req_ready, 1'b0);
    check("t6_rsp_ready_cleared", m_rsp_ready[0] | m_rsp_ready[1], 1'b0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    seen_rsp = 0;
    seen_req = 0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
      if (m_req_valid[0] || m_req_valid[1]) seen_req++;
    end
    rsp_ready = 1'b0;
    check("t6_no_rsp_after_reset", seen_rsp, 0);
    check("t6_fifo_flushed", seen_req, 0);
    clear_logs();
    send(32'h1100, 32'h700, 16'd8, 1'b1, 4'd12);
    wait_rsp(4'd12, 100, lat);
    check("t6_new_latency", lat, 7);
    check("t6_new_nwrites", wa_log[1].size(), 2);
    for (int k = 0; k < 2; k++) check("t6_new_data", mem[1][32'h1C0 + k], pat(0, 32'h440 + k));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
